// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter and its ALU.
//   - ALU operation select encodings (ALU_ADD .. ALU_NOT)
//   - arbiter FSM state type
//   - sel_legal(): reports whether an op select is one the ALU implements
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes above ALU_NOT (101, 110, 111) are unassigned.
  function automatic logic sel_legal(input logic [2:0] sel);
    return (sel <= ALU_NOT);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: 32-bit combinational ALU.
// Ports:
//   opA, opB  in  32  operands
//   sel       in   3  operation select (see alu_pkg)
//   res       out 32  result (0 for an illegal select)
//   z, c, v   out  1  zero, carry/borrow and signed-overflow flags
//                     (all 0 for an illegal select)
module alu
  import alu_pkg::*;
(
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [2:0]  sel,
  output logic [31:0] res,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic [32:0] sum;
  logic [32:0] diff;

  // Both 33-bit results are formed up front; bit 32 is the carry for ADD
  // and the borrow for SUB.
  always_comb begin
    sum  = {1'b0, opA} + {1'b0, opB};
    diff = {1'b0, opA} - {1'b0, opB};
    res  = 32'd0;
    c    = 1'b0;
    v    = 1'b0;
    case (sel)
      ALU_ADD: begin
        res = sum[31:0];
        c   = sum[32];
        v   = (opA[31] == opB[31]) && (sum[31] != opA[31]);
      end
      ALU_SUB: begin
        res = diff[31:0];
        c   = diff[32];
        v   = (opA[31] != opB[31]) && (diff[31] != opA[31]);
      end
      ALU_AND: res = opA & opB;
      ALU_OR:  res = opA | opB;
      ALU_NOT: res = ~opA;
      default: res = 32'd0;
    endcase
    // An illegal select leaves res at 0 but must still report z=0.
    z = sel_legal(sel) && (res == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: time-shares one ALU between two requesters.
// A grant latches the winner's operands, the next cycle (EXEC) registers
// the ALU outputs into the response registers, and the response is then
// held in RESP until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid[1:0]        requester i has an operation
//   req_ready[1:0]        requester i accepted this cycle (one-hot or 0)
//   req_opA/req_opB[63:0] operand A/B of requester i at [32i+31:32i]
//   req_sel[5:0]          op select of requester i at [3i+2:3i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                requester that issued the response
//   rsp_res, rsp_z/c/v    ALU result and flags
//   rsp_err               select was illegal
// Parameter RR: 1 = round-robin, 0 = requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_opA,
  input  logic [63:0] req_opB,
  input  logic [5:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        rsp_z,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_err
);

  state_t      state;
  logic        last_grant;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sel;
  logic        op_id;

  logic        can_grant;
  logic        accept;
  logic        grant_id;

  logic [31:0] alu_res;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;

  alu u_alu (
    .opA (op_a),
    .opB (op_b),
    .sel (op_sel),
    .res (alu_res),
    .z   (alu_z),
    .c   (alu_c),
    .v   (alu_v)
  );

  // Grant selection. With a single valid requester, ~req_valid[0] picks it
  // directly; that same expression also gives fixed priority to requester 0.
  // Only round-robin contention consults last_grant, so a requester that
  // withdraws before winning leaves the rotation untouched.
  always_comb begin
    can_grant = !rst && ((state == ST_IDLE) ||
                         ((state == ST_RESP) && rsp_ready));
    accept    = can_grant && (req_valid != 2'b00);
    if ((RR != 0) && (req_valid == 2'b11)) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~req_valid[0];
    end
    req_ready = 2'b00;
    if (accept) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_sel     <= 3'd0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= 32'd0;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      // accept is only ever true in IDLE or in RESP with rsp_ready, so the
      // operand capture is shared by both grant points.
      if (accept) begin
        op_a       <= grant_id ? req_opA[63:32] : req_opA[31:0];
        op_b       <= grant_id ? req_opB[63:32] : req_opB[31:0];
        op_sel     <= grant_id ? req_sel[5:3]   : req_sel[2:0];
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_res   <= alu_res;
          rsp_z     <= alu_z;
          rsp_c     <= alu_c;
          rsp_v     <= alu_v;
          rsp_err   <= !sel_legal(op_sel);
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// Two instances share stimulus: dut (round-robin) and dut_fp (fixed
// priority). Expected values come from constants and a transaction-level
// reference model of the ALU and the arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_opA;
  logic [63:0] req_opB;
  logic [5:0]  req_sel;
  logic        rsp_ready;

  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_z, rsp_c, rsp_v, rsp_err;
  logic [31:0] rsp_res;

  logic [1:0]  fp_req_ready;
  logic        fp_rsp_valid, fp_rsp_id, fp_rsp_z, fp_rsp_c, fp_rsp_v, fp_rsp_err;
  logic [31:0] fp_rsp_res;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct {
    logic [31:0] res;
    logic        z, c, v, err;
  } alu_out_t;

  alu_arbiter #(.RR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_err(rsp_err)
  );

  alu_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_sel(req_sel),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_res(fp_rsp_res), .rsp_z(fp_rsp_z), .rsp_c(fp_rsp_c),
    .rsp_v(fp_rsp_v), .rsp_err(fp_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from plain arithmetic: overflow means the true signed
  // result falls outside the 32-bit range, carry means the true unsigned
  // sum exceeds 32 bits, borrow means opA < opB.
  function automatic alu_out_t alu_model(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0] sel);
    alu_out_t o;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    o.res = 32'd0; o.c = 1'b0; o.v = 1'b0; o.err = 1'b0;
    case (sel)
      3'd0: begin
        o.res = a + b;
        o.c   = (ua + ub) > 64'hFFFF_FFFF;
        sr    = sa + sb;
        o.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        o.res = a - b;
        o.c   = (a < b);
        sr    = sa - sb;
        o.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: o.res = a & b;
      3'd3: o.res = a | b;
      3'd4: o.res = ~a;
      default: o.err = 1'b1;
    endcase
    o.z = !o.err && (o.res == 32'd0);
    return o;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    n_compared++;
    if (req_ready !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL reset_req_ready got=%b want=00", req_ready);
    end
    tick();
    #1;
    n_compared++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err} !== 38'd0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_rsp got valid=%b id=%b res=%h zcv=%b%b%b err=%b want all 0",
               rsp_valid, rsp_id, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err);
    end
    n_compared++;
    if (req_ready !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL reset_req_ready_held got=%b want=00", req_ready);
    end
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_add_overflow();
    do_reset();
    req_valid = 2'b01;
    req_opA = {32'd0, 32'h7FFF_FFFF};
    req_opB = {32'd0, 32'h0000_0001};
    req_sel = 6'b000_000;
    rsp_ready = 1'b1;
    #1;
    n_compared++;
    if (req_ready !== 2'b01) begin
      n_mismatch++;
      $display("[TB] FAIL add_accept got=%b want=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL add_exec got valid=%b ready=%b want 0/00", rsp_valid, req_ready);
    end
    tick();
    #1;
    n_compared++;
    if ({rsp_valid, rsp_res, rsp_v, rsp_c, rsp_z, rsp_id, rsp_err} !==
        {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_mismatch++;
      $display("[TB] FAIL add_overflow got valid=%b res=%h v=%b c=%b z=%b id=%b want 1/80000000/1/0/0/0",
               rsp_valid, rsp_res, rsp_v, rsp_c, rsp_z, rsp_id);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_ready [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic       exp_id;
    do_reset();
    req_valid = 2'b11;
    req_opA = {32'd3, 32'd5};
    req_opB = {32'd5, 32'd5};
    req_sel = 6'b001_001;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      #1;
      n_compared++;
      if (req_ready !== exp_ready[cyc]) begin
        n_mismatch++;
        $display("[TB] FAIL alt_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready[cyc]);
      end
      n_compared++;
      if (rsp_valid !== (cyc >= 2 && cyc % 2 == 0)) begin
        n_mismatch++;
        $display("[TB] FAIL alt_rsp_valid cyc=%0d got=%b", cyc, rsp_valid);
      end
      if (cyc >= 2 && cyc % 2 == 0) begin
        exp_id = (cyc == 4);
        n_compared++;
        if (exp_id == 1'b0 &&
            {rsp_id, rsp_res, rsp_z, rsp_c, rsp_v} !== {1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
          n_mismatch++;
          $display("[TB] FAIL alt_req0 cyc=%0d got id=%b res=%h zcv=%b%b%b want 0/00000000/100",
                   cyc, rsp_id, rsp_res, rsp_z, rsp_c, rsp_v);
        end else if (exp_id == 1'b1 &&
            {rsp_id, rsp_res, rsp_z, rsp_c, rsp_v} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0}) begin
          n_mismatch++;
          $display("[TB] FAIL alt_req1 cyc=%0d got id=%b res=%h zcv=%b%b%b want 1/fffffffe/010",
                   cyc, rsp_id, rsp_res, rsp_z, rsp_c, rsp_v);
        end
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    alu_out_t e;
    logic [31:0] a0, b0;
    do_reset();
    a0 = rand_operand();
    b0 = rand_operand();
    e = alu_model(a0, b0, 3'd2);
    req_valid = 2'b01;
    req_opA = {32'h1234_5678, a0};
    req_opB = {32'h0000_0001, b0};
    req_sel = 6'b000_010;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_compared++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_err, req_ready} !== {1'b1, 1'b0, e.res, 1'b0, 2'b00}) begin
        n_mismatch++;
        $display("[TB] FAIL bp_hold k=%0d got valid=%b id=%b res=%h ready=%b want 1/0/%h/00",
                 k, rsp_valid, rsp_id, rsp_res, req_ready, e.res);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_compared++;
    if (req_ready !== 2'b10) begin
      n_mismatch++;
      $display("[TB] FAIL bp_release_grant got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_compared++;
    if (rsp_valid !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL bp_exec_valid got=%b want=0", rsp_valid);
    end
    tick();
    e = alu_model(32'h1234_5678, 32'h0000_0001, 3'd0);
    #1;
    n_compared++;
    if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b1, e.res}) begin
      n_mismatch++;
      $display("[TB] FAIL bp_req1_rsp got valid=%b id=%b res=%h want 1/1/%h",
               rsp_valid, rsp_id, rsp_res, e.res);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    req_valid = 2'b10;
    req_opA = {rand_operand(), rand_operand()};
    req_opB = {rand_operand(), rand_operand()};
    req_sel = 6'b110_000;
    rsp_ready = 1'b1;
    #1;
    n_compared++;
    if (req_ready !== 2'b10) begin
      n_mismatch++;
      $display("[TB] FAIL illegal_accept got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    n_compared++;
    if ({rsp_valid, rsp_err, rsp_res, rsp_z, rsp_c, rsp_v, rsp_id} !==
        {1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_mismatch++;
      $display("[TB] FAIL illegal_rsp got valid=%b err=%b res=%h zcv=%b%b%b id=%b want 1/1/0/000/1",
               rsp_valid, rsp_err, rsp_res, rsp_z, rsp_c, rsp_v, rsp_id);
    end
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req_valid = 2'b11;
    req_opA = {rand_operand(), rand_operand()};
    req_opB = {rand_operand(), rand_operand()};
    req_sel = 6'b000_011;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      n_compared++;
      if (fp_req_ready !== ((cyc % 2 == 0) ? 2'b01 : 2'b00)) begin
        n_mismatch++;
        $display("[TB] FAIL fp_grant cyc=%0d got=%b", cyc, fp_req_ready);
      end
      if (cyc >= 2 && cyc % 2 == 0) begin
        n_compared++;
        if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b0) begin
          n_mismatch++;
          $display("[TB] FAIL fp_rsp cyc=%0d got valid=%b id=%b want 1/0", cyc, fp_rsp_valid, fp_rsp_id);
        end
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    req_valid = 2'b01;
    req_opA = {32'd0, 32'd7};
    req_opB = {32'd0, 32'd9};
    req_sel = 6'b000_000;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
        n_mismatch++;
        $display("[TB] FAIL rst_exec_discard k=%0d got valid=%b ready=%b want 0/00", k, rsp_valid, req_ready);
      end
      tick();
    end
    req_valid = 2'b01;
    #1;
    n_compared++;
    if (req_ready !== 2'b01) begin
      n_mismatch++;
      $display("[TB] FAIL rst_exec_idle got=%b want=01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  // Transaction-level model: one operation in flight, one response slot,
  // and the round-robin pointer.
  task automatic test_random();
    bit          m_exec = 0;
    bit          m_rv = 0;
    int          m_last = 1;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_sel;
    int          m_id = 0;
    int          m_rid = 0;
    alu_out_t    m_rsp;
    bit          can;
    int          g;
    logic [1:0]  exp_ready;
    do_reset();
    m_rsp = alu_model(32'd0, 32'd0, 3'd0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_opA = {rand_operand(), rand_operand()};
      req_opB = {rand_operand(), rand_operand()};
      req_sel = 6'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      n_compared++;
      if (rsp_valid !== m_rv) begin
        n_mismatch++;
        $display("[TB] FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, m_rv);
      end
      if (m_rv) begin
        n_compared++;
        if ({rsp_id, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err} !==
            {1'(m_rid), m_rsp.res, m_rsp.z, m_rsp.c, m_rsp.v, m_rsp.err}) begin
          n_mismatch++;
          $display("[TB] FAIL rnd_rsp cyc=%0d got id=%b res=%h zcve=%b%b%b%b want %0d/%h/%b%b%b%b",
                   cyc, rsp_id, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err,
                   m_rid, m_rsp.res, m_rsp.z, m_rsp.c, m_rsp.v, m_rsp.err);
        end
      end
      can = !m_exec && (!m_rv || rsp_ready);
      g = -1;
      if (can && req_valid != 2'b00) begin
        if (req_valid == 2'b11) g = 1 - m_last;
        else g = req_valid[1] ? 1 : 0;
      end
      exp_ready = (g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
      n_compared++;
      if (req_ready !== exp_ready) begin
        n_mismatch++;
        $display("[TB] FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready);
      end
      if (m_exec) begin
        m_rsp = alu_model(m_a, m_b, m_sel);
        m_rid = m_id;
        m_rv = 1;
        m_exec = 0;
      end else if (m_rv && rsp_ready) begin
        m_rv = 0;
      end
      if (g >= 0) begin
        m_exec = 1;
        m_a = (g == 1) ? req_opA[63:32] : req_opA[31:0];
        m_b = (g == 1) ? req_opB[63:32] : req_opB[31:0];
        m_sel = (g == 1) ? req_sel[5:3] : req_sel[2:0];
        m_id = g;
        m_last = g;
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_opA = 64'd0;
    req_opB = 64'd0;
    req_sel = 6'd0;
    rsp_ready = 1'b0;
    tick();
    test_reset();
    test_add_overflow();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_fixed_priority();
    test_reset_in_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
